// File: rtl/axc_booth_pkg.sv
// Shared definitions for the axc_booth_lanes approximate Booth multiplier:
// one-hot FSM state encoding and width helpers for the term budget and the
// accumulator.
`timescale 1ns/1ps
package axc_booth_pkg;

  // One-hot controller states.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_RECODE = 4'b0010,
    ST_MULT   = 4'b0100,
    ST_DONE   = 4'b1000
  } state_e;

  // Width of the term budget. It must hold every Booth digit count, up to NA+1.
  function automatic int nc_width(input int na);
    return $clog2(na + 2) + 1;
  endfunction

  // Accumulator width: product width plus one bit of headroom for
  // partial MSB-first sums.
  function automatic int acc_width(input int na, input int nb);
    return na + nb + 1;
  endfunction

endpackage

// File: rtl/booth_term_pick.sv
// Masked MSB-first priority picker. From the pending positive/negative
// digit masks it selects up to LANES of the highest pending digits. The
// number of selections is limited by the remaining term budget. Each
// selection is returned one-hot, with its bit index and its polarity.
`timescale 1ns/1ps
module booth_term_pick #(
  parameter int ND    = 13,
  parameter int LANES = 1,
  parameter int NC    = 5,
  parameter int IW    = $clog2(ND)
) (
  input  logic [ND-1:0]             pos_mask,
  input  logic [ND-1:0]             neg_mask,
  input  logic [NC-1:0]             budget,
  output logic [LANES-1:0][ND-1:0]  sel_oh,
  output logic [LANES-1:0][IW-1:0]  sel_idx,
  output logic [LANES-1:0]          sel_neg,
  output logic [LANES-1:0]          sel_vld
);

  // Peel off the highest remaining digit once per lane, stopping at the budget.
  always_comb begin
    logic [ND-1:0] avail;
    logic          found;
    // NOTE: every output gets a default before any branch. A path that
    // leaves one unassigned would infer a latch.
    avail   = pos_mask | neg_mask;
    found   = 1'b0;
    sel_oh  = '0;
    sel_idx = '0;
    sel_neg = '0;
    sel_vld = '0;
    for (int l = 0; l < LANES; l++) begin
      found = 1'b0;
      for (int i = ND - 1; i >= 0; i--) begin
        if (!found && avail[i] && (l < int'(budget))) begin
          found      = 1'b1;
          sel_oh[l]  = ND'(1) << i;
          sel_idx[l] = IW'(i);
          sel_neg[l] = neg_mask[i];
          sel_vld[l] = 1'b1;
        end
      end
      avail = avail & ~sel_oh[l];
    end
  end

endmodule

// File: rtl/axc_booth_lanes.sv
// Tunable approximate radix-2 Booth multiplier tile.
// A is Booth-recoded with a[-1]=0. In unsigned mode an extra top digit
// d[NA] = +a[NA-1] is added. Nonzero digits are applied MSB-first as
// +/-(B << i), up to LANES per cycle, until the caller's term budget runs
// out. Exact_out reports that no digit was left unapplied.
// Optional build macro: AXC_BOOTH_TERMCNT_EN adds Terms_out, which gives
// the number of digits applied.
`timescale 1ns/1ps
module axc_booth_lanes
  import axc_booth_pkg::*;
#(
  parameter int NA    = 12,
  parameter int NB    = 12,
  parameter int LANES = 1,
  parameter int NC    = nc_width(NA)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                In_valid,
  output logic                In_ready,
  input  logic                Signed_in,
  input  logic [NA-1:0]       A_in,
  input  logic [NB-1:0]       B_in,
  input  logic [NC-1:0]       C_in,
  output logic                Out_valid,
  input  logic                Out_ready,
  output logic [NA+NB-1:0]    N_out,
  output logic                Exact_out
`ifdef AXC_BOOTH_TERMCNT_EN
  ,
  output logic [NC-1:0]       Terms_out
`endif
);

  localparam int ND = NA + 1;            // digit positions 0..NA
  localparam int AW = acc_width(NA, NB);
  localparam int IW = $clog2(ND);

  state_e                     state_q, state_d;
  logic [NA-1:0]              a_q, a_d;
  logic [NB-1:0]              b_q, b_d;
  logic                       sgn_q, sgn_d;
  logic [NC-1:0]              budget_q, budget_d;
  logic [ND-1:0]              pos_q, pos_d;
  logic [ND-1:0]              neg_q, neg_d;
  logic [AW-1:0]              acc_q, acc_d;
`ifdef AXC_BOOTH_TERMCNT_EN
  logic [NC-1:0]              terms_q, terms_d;
`endif

  logic                       accept;
  logic [NA+1:0]              a_ext;
  logic [ND-1:0]              rec_pos, rec_neg;
  logic [AW-1:0]              b_ext;
  logic [LANES-1:0][ND-1:0]   pick_oh;
  logic [LANES-1:0][IW-1:0]   pick_idx;
  logic [LANES-1:0]           pick_neg;
  logic [LANES-1:0]           pick_vld;
  logic [LANES-1:0][AW-1:0]   lane_term;
  logic [NC-1:0]              applied;
  logic                       acc_msb_unused;

  assign accept    = (state_q == ST_IDLE) && In_valid;
  assign In_ready  = (state_q == ST_IDLE);
  assign Out_valid = (state_q == ST_DONE);
  assign N_out     = acc_q[NA+NB-1:0];
  assign Exact_out = (state_q == ST_DONE) && ((pos_q | neg_q) == '0);
`ifdef AXC_BOOTH_TERMCNT_EN
  assign Terms_out = terms_q;
`endif
  // The top accumulator bit is headroom only. The product is the low NA+NB bits.
  assign acc_msb_unused = acc_q[AW-1];

  // Capture the operands when an operation is accepted.
  always_comb begin
    a_d   = accept ? A_in      : a_q;
    b_d   = accept ? B_in      : b_q;
    sgn_d = accept ? Signed_in : sgn_q;
  end

  // Booth recoding: d[i] = a[i-1] - a[i]. a_ext[0] is a[-1], and the top bit
  // repeats the sign (signed) or is zero (unsigned, producing d[NA] = +a[NA-1]).
  always_comb begin
    a_ext = {sgn_q & a_q[NA-1], a_q, 1'b0};
    for (int i = 0; i < ND; i++) begin
      rec_pos[i] = a_ext[i] & ~a_ext[i+1];
      rec_neg[i] = ~a_ext[i] & a_ext[i+1];
    end
  end

  // Extend B into the accumulator width, then shift one copy per lane.
  always_comb begin
    b_ext = {{(AW-NB){sgn_q & b_q[NB-1]}}, b_q};
    for (int l = 0; l < LANES; l++) begin
      lane_term[l] = b_ext << pick_idx[l];
    end
  end

  booth_term_pick #(
    .ND    (ND),
    .LANES (LANES),
    .NC    (NC),
    .IW    (IW)
  ) u_pick (
    .pos_mask (pos_q),
    .neg_mask (neg_q),
    .budget   (budget_q),
    .sel_oh   (pick_oh),
    .sel_idx  (pick_idx),
    .sel_neg  (pick_neg),
    .sel_vld  (pick_vld)
  );

  // Next-state logic. The accumulation and mask/budget bookkeeping happen here too.
  always_comb begin
    state_d  = state_q;
    budget_d = budget_q;
    pos_d    = pos_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    applied  = '0;
`ifdef AXC_BOOTH_TERMCNT_EN
    terms_d  = terms_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          budget_d = C_in;
          state_d  = ST_RECODE;
        end
      end
      ST_RECODE: begin
        pos_d = rec_pos;
        neg_d = rec_neg;
        acc_d = '0;
`ifdef AXC_BOOTH_TERMCNT_EN
        terms_d = '0;
`endif
        if ((budget_q == '0) || ((rec_pos | rec_neg) == '0)) state_d = ST_DONE;
        else                                                  state_d = ST_MULT;
      end
      ST_MULT: begin
        for (int l = 0; l < LANES; l++) begin
          if (pick_vld[l]) begin
            applied = applied + NC'(1);
            acc_d   = pick_neg[l] ? (acc_d - lane_term[l]) : (acc_d + lane_term[l]);
            pos_d   = pos_d & ~pick_oh[l];
            neg_d   = neg_d & ~pick_oh[l];
          end
        end
        budget_d = budget_q - applied;
`ifdef AXC_BOOTH_TERMCNT_EN
        terms_d  = terms_q + applied;
`endif
        if ((budget_d == '0) || ((pos_d | neg_d) == '0)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (Out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and result registers, cleared by the synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments. Every flop then
    // updates from pre-edge values, whatever order the statements are in.
    if (RST) begin
      state_q  <= ST_IDLE;
      budget_q <= '0;
      pos_q    <= '0;
      neg_q    <= '0;
      acc_q    <= '0;
`ifdef AXC_BOOTH_TERMCNT_EN
      terms_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      budget_q <= budget_d;
      pos_q    <= pos_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
`ifdef AXC_BOOTH_TERMCNT_EN
      terms_q  <= terms_d;
`endif
    end
  end

  // Operand holding registers.
  always_ff @(posedge CLK) begin
    // NOTE: these registers are deliberately not reset. They are only read
    // after an accept has loaded them, so a reset would add fan-out and
    // change no behaviour.
    a_q   <= a_d;
    b_q   <= b_d;
    sgn_q <= sgn_d;
  end

endmodule

// File: tb/tb_axc_booth_lanes.sv
// Self-checking bench for axc_booth_lanes (NA=NB=8). Two instances share the
// stimulus: one with LANES=1 and one with LANES=2. Expected products,
// exactness and latency come from an integer reference model of the
// truncated MSB-first Booth sum.
`timescale 1ns/1ps
module tb_axc_booth_lanes;

  localparam int NA = 8;
  localparam int NB = 8;
  localparam int NC = 5;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic signed_in;
  logic [NA-1:0] a_in;
  logic [NB-1:0] b_in;
  logic [NC-1:0] c_in;
  logic out_ready;

  logic rdy1, rdy2, ov1, ov2, ex1, ex2;
  logic [NA+NB-1:0] n1, n2;
`ifdef AXC_BOOTH_TERMCNT_EN
  logic [NC-1:0] t1, t2;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axc_booth_lanes #(.NA(NA), .NB(NB), .LANES(1), .NC(NC)) u_dut1 (
    .CLK(clk), .RST(rst), .In_valid(in_valid), .In_ready(rdy1),
    .Signed_in(signed_in), .A_in(a_in), .B_in(b_in), .C_in(c_in),
    .Out_valid(ov1), .Out_ready(out_ready), .N_out(n1), .Exact_out(ex1)
`ifdef AXC_BOOTH_TERMCNT_EN
    , .Terms_out(t1)
`endif
  );

  axc_booth_lanes #(.NA(NA), .NB(NB), .LANES(2), .NC(NC)) u_dut2 (
    .CLK(clk), .RST(rst), .In_valid(in_valid), .In_ready(rdy2),
    .Signed_in(signed_in), .A_in(a_in), .B_in(b_in), .C_in(c_in),
    .Out_valid(ov2), .Out_ready(out_ready), .N_out(n2), .Exact_out(ex2)
`ifdef AXC_BOOTH_TERMCNT_EN
    , .Terms_out(t2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: apply up to c nonzero Booth digits, highest position first.
  function automatic void model(input bit sgn, input logic [7:0] a, input logic [7:0] b,
                                input int c, output logic [15:0] n, output bit exact,
                                output int used, output logic [15:0] prod);
    int bv, av, acc, nz, d, prev, cur, top;
    av   = sgn ? int'($signed(a)) : int'(a);
    bv   = sgn ? int'($signed(b)) : int'(b);
    top  = sgn ? 7 : 8;
    acc  = 0;
    used = 0;
    nz   = 0;
    for (int i = top; i >= 0; i--) begin
      prev = (i == 0) ? 0 : int'(a[i-1]);
      cur  = (i < 8) ? int'(a[i]) : 0;
      d    = prev - cur;
      if (d != 0) begin
        nz++;
        if (used < c) begin
          acc = acc + d * bv * (1 << i);
          used++;
        end
      end
    end
    n     = acc[15:0];
    exact = (used == nz);
    prod  = 16'(av * bv);
  endfunction

  function automatic int exp_lat(input int used, input int lanes);
    return 2 + (used + lanes - 1) / lanes;
  endfunction

  // Called #1 after the accept edge with Out_ready=1; returns with both tiles idle.
  task automatic wait_results(input string tag, input logic [15:0] en, input bit ex,
                              input int used, input logic [15:0] prod);
    int lat;
    bit d1, d2;
    lat = 1;
    d1  = 1'b0;
    d2  = 1'b0;
    while (!(d1 && d2) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (!d1 && ov1) begin
        d1 = 1'b1;
        check({tag, "/n_l1"}, n1, en);
        check({tag, "/exact_l1"}, ex1, ex);
        check({tag, "/lat_l1"}, lat, exp_lat(used, 1));
        if (ex) check({tag, "/prod_l1"}, n1, prod);
`ifdef AXC_BOOTH_TERMCNT_EN
        check({tag, "/terms_l1"}, t1, used);
`endif
      end
      if (!d2 && ov2) begin
        d2 = 1'b1;
        check({tag, "/n_l2"}, n2, en);
        check({tag, "/exact_l2"}, ex2, ex);
        check({tag, "/lat_l2"}, lat, exp_lat(used, 2));
`ifdef AXC_BOOTH_TERMCNT_EN
        check({tag, "/terms_l2"}, t2, used);
`endif
      end
    end
    check({tag, "/done_l1"}, d1, 1);
    check({tag, "/done_l2"}, d2, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_op(input string tag, input bit sgn, input logic [7:0] a,
                        input logic [7:0] b, input int c);
    logic [15:0] en, prod;
    bit ex;
    int used;
    model(sgn, a, b, c, en, ex, used, prod);
    signed_in = sgn;
    a_in      = a;
    b_in      = b;
    c_in      = NC'(c);
    in_valid  = 1'b1;
    check({tag, "/in_ready"}, {rdy1, rdy2}, 2'b11);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_results(tag, en, ex, used, prod);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] en, prod, en2, prod2;
    bit ex, ex2b;
    int used, used2, cyc;

    rst = 1'b1; in_valid = 1'b0; signed_in = 1'b0;
    a_in = '0; b_in = '0; c_in = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset/in_ready", {rdy1, rdy2}, 2'b11);
    check("reset/out_valid", {ov1, ov2}, 2'b00);
    check("reset/n_out", {n1, n2}, 32'h0);
    check("reset/exact", {ex1, ex2}, 2'b00);
`ifdef AXC_BOOTH_TERMCNT_EN
    check("reset/terms", {t1, t2}, 0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    run_op("u7x10_c1",   1'b0, 8'd7,   8'd10, 1);
    run_op("u7x10_c2",   1'b0, 8'd7,   8'd10, 2);
    run_op("s-3x5_c1",   1'b1, 8'hFD,  8'd5,  1);
    run_op("s-3x5_c3",   1'b1, 8'hFD,  8'd5,  3);
    run_op("u253x5_c4",  1'b0, 8'hFD,  8'd5,  4);
    run_op("u55x3_c15",  1'b0, 8'h55,  8'd3,  15);
    run_op("c0_u",       1'b0, 8'h9C,  8'h21, 0);
    run_op("c0_s",       1'b1, 8'h81,  8'hE7, 0);
    run_op("a0_u",       1'b0, 8'h00,  8'h37, 5);
    run_op("a0_s",       1'b1, 8'h00,  8'hC8, 5);
    run_op("s_min_min",  1'b1, 8'h80,  8'h80, 31);
    run_op("u_max_max",  1'b0, 8'hFF,  8'hFF, 31);
    run_op("s_alt_c2",   1'b1, 8'hAA,  8'h7F, 2);

    // Backpressure: hold the result, ignore a second offer, then accept it
    out_ready = 1'b0;
    model(1'b0, 8'hB7, 8'h5A, 31, en, ex, used, prod);
    signed_in = 1'b0; a_in = 8'hB7; b_in = 8'h5A; c_in = 5'd31; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!(ov1 && ov2) && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("bp/valid", {ov1, ov2}, 2'b11);
    check("bp/n_l1", n1, en);
    check("bp/n_l2", n2, en);
    check("bp/exact", {ex1, ex2}, {ex, ex});
    model(1'b1, 8'h9A, 8'h3C, 3, en2, ex2b, used2, prod2);
    signed_in = 1'b1; a_in = 8'h9A; b_in = 8'h3C; c_in = 5'd3; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp/hold_valid", {ov1, ov2}, 2'b11);
      check("bp/hold_n", {n1, n2}, {en, en});
      check("bp/hold_in_ready", {rdy1, rdy2}, 2'b00);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp/release_idle", {rdy1, rdy2, ov1, ov2}, 4'b1100);
    @(posedge clk); #1;
    check("bp/second_accepted", {rdy1, rdy2}, 2'b00);
    in_valid = 1'b0;
    wait_results("bp/second", en2, ex2b, used2, prod2);

    // Synchronous reset in the middle of MULT
    signed_in = 1'b0; a_in = 8'h55; b_in = 8'd3; c_in = 5'd15; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_mult/busy", {rdy1, rdy2, ov1, ov2}, 4'b0000);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mult/in_ready", {rdy1, rdy2}, 2'b11);
    check("rst_mult/out_valid", {ov1, ov2}, 2'b00);
    check("rst_mult/n_out", {n1, n2}, 32'h0);
    run_op("rst_mult/fresh", 1'b1, 8'hC3, 8'h6D, 31);

    // Randomized operations
    for (int r = 0; r < 60; r++) begin
      run_op($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 8'($urandom),
             8'($urandom), int'($urandom_range(0, 12)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
